// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-sequencing stage: datapath width,
// branch funct3 encodings and the sequencing FSM state type.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Conditional-branch funct3 encodings (010/011 are unused and never taken)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: maps funct3 and the ULA compare flags (ULA
// running a subtraction rs1-rs2) onto a single taken/not-taken bit.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       EQ,
  input  logic       GT_SN,
  input  logic       LT_SN,
  input  logic       GT_UN,
  input  logic       LT_UN,
  output logic       cond
);

  // Greater-than flags are implied by ~EQ & ~LT, so the decode only needs EQ/LT.
  logic unused_gt_flags;
  assign unused_gt_flags = GT_SN ^ GT_UN;

  // Select the condition; undefined encodings resolve to not-taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = EQ;
      F3_BNE:  cond = ~EQ;
      F3_BLT:  cond = LT_SN;
      F3_BGE:  cond = ~LT_SN;
      F3_BLTU: cond = LT_UN;
      F3_BGEU: cond = ~LT_UN;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Multi-cycle, non-pipelined instruction sequencer: owns the PC, runs the
// fetch req/ack handshake, and after execute forms the next PC from
// JAL/JALR/conditional branches. A misaligned target parks the unit in TRAP.
module pc_branch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_req,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic [31:0]     instr_in,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            EQ,
  input  logic            GT_SN,
  input  logic            LT_SN,
  input  logic            GT_UN,
  input  logic            LT_UN,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            taken,
  output logic            misaligned
);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     instr_reg;
  logic            taken_reg;
  logic            misaligned_reg;

  logic            cond;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            target_misaligned;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .EQ     (EQ),
    .GT_SN  (GT_SN),
    .LT_SN  (LT_SN),
    .GT_UN  (GT_UN),
    .LT_UN  (LT_UN),
    .cond   (cond)
  );

  // All adders wrap modulo 2^XLEN; there is deliberately no overflow detection.
  assign pc_plus4   = pc_reg + XLEN'(4);
  assign rel_target = pc_reg + imm;
  assign jalr_sum   = rs1_val + imm;

  // Next-PC selection: JALR beats JAL beats a taken branch beats fall-through.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (is_jalr) begin
      next_pc  = {jalr_sum[XLEN-1:1], 1'b0};
      redirect = 1'b1;
    end else if (is_jal) begin
      next_pc  = rel_target;
      redirect = 1'b1;
    end else if (is_branch && cond) begin
      next_pc  = rel_target;
      redirect = 1'b1;
    end
  end

  assign target_misaligned = |next_pc[1:0];

  // Sequencing FSM; PC, latched instruction and status flags move with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_VECTOR;
      instr_reg      <= '0;
      taken_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH: begin
          // ex_done is meaningless here and is ignored even alongside an ack
          if (fetch_ack) begin
            instr_reg <= instr_in;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // a stray fetch_ack here is ignored
          if (ex_done) begin
            taken_reg <= redirect;
            if (target_misaligned) begin
              misaligned_reg <= 1'b1;
              state_reg      <= TRAP;
            end else begin
              pc_reg    <= next_pc;
              state_reg <= FETCH;
            end
          end
        end
        TRAP:    state_reg <= TRAP;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register so that reset
  // removes them immediately.
  assign fetch_req   = (state_reg == FETCH);
  assign instr_valid = (state_reg == EXEC);
  assign fetch_addr  = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign taken       = taken_reg;
  assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset/handshake latency, a table of
// control-transfer vectors, and hand-written ignore/reset/trap sequences.
module tb_pc_branch_unit;

  localparam logic [63:0] RV = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [63:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] instr_in;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [63:0] imm, rs1_val;
  logic        EQ, GT_SN, LT_SN, GT_UN, LT_UN;
  logic [63:0] pc, pc_plus4;
  logic        taken, misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.XLEN(64), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .instr_in(instr_in),
    .instr(instr), .instr_valid(instr_valid),
    .ex_done(ex_done), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .imm(imm), .rs1_val(rs1_val),
    .EQ(EQ), .GT_SN(GT_SN), .LT_SN(LT_SN), .GT_UN(GT_UN), .LT_UN(LT_UN),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .misaligned(misaligned)
  );

  typedef struct {
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [63:0] rs1;
    logic        eq;
    logic        lt_sn;
    logic        lt_un;
    logic [63:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic br, jal, jalr, input logic [2:0] f3,
                              input logic [63:0] im, r1, input logic eq, ls, lu,
                              input logic [63:0] epc, input logic et);
    vec_t v;
    v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3; v.imm = im; v.rs1 = r1;
    v.eq = eq; v.lt_sn = ls; v.lt_un = lu; v.exp_pc = epc; v.exp_taken = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_exec_inputs();
    ex_done = 0; is_branch = 0; is_jal = 0; is_jalr = 0; funct3 = 3'b000;
    imm = '0; rs1_val = '0; EQ = 0; LT_SN = 0; LT_UN = 0; GT_SN = 0; GT_UN = 0;
  endtask

  task automatic drive_exec(input vec_t v);
    is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr; funct3 = v.f3;
    imm = v.imm; rs1_val = v.rs1;
    EQ = v.eq; LT_SN = v.lt_sn; LT_UN = v.lt_un;
    GT_SN = ~v.eq & ~v.lt_sn; GT_UN = ~v.eq & ~v.lt_un;
  endtask

  // Waits (bounded) for fetch_req, acks one word, checks the latch one cycle later.
  task automatic do_fetch(input logic [31:0] w, input string tag);
    int k = 0;
    while (!fetch_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " fetch_req"}, 64'(fetch_req), 64'd1);
    fetch_ack = 1; instr_in = w;
    @(negedge clk);
    fetch_ack = 0; instr_in = '0;
    chk({tag, " instr_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, " instr"}, 64'(instr), 64'(w));
  endtask

  // One-cycle ex_done pulse with the given decode; outputs are settled afterwards.
  task automatic do_exec(input vec_t v);
    drive_exec(v);
    ex_done = 1;
    @(negedge clk);
    clear_exec_inputs();
  endtask

  initial begin
    vec_t v;
    logic [31:0] w0;

    reset = 1; fetch_ack = 0; instr_in = '0;
    clear_exec_inputs();

    // Reset values, IDLE for one cycle, then FETCH with a 3-cycle ack delay
    repeat (3) @(negedge clk);
    chk("reset pc", pc, RV);
    chk("reset instr", 64'(instr), 64'd0);
    chk("reset taken", 64'(taken), 64'd0);
    chk("reset misaligned", 64'(misaligned), 64'd0);
    reset = 0;
    #1;
    chk("idle fetch_req", 64'(fetch_req), 64'd0);
    chk("idle instr_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("first fetch_req", 64'(fetch_req), 64'd1);
    chk("first fetch_addr", fetch_addr, RV);
    repeat (3) begin
      @(negedge clk);
      chk("fetch_req held", 64'(fetch_req), 64'd1);
      chk("no instr_valid while fetching", 64'(instr_valid), 64'd0);
    end
    w0 = 32'h0000_0063;
    do_fetch(w0, "reset seq");
    $display("reset sequence: pc=%h instr=%h", pc, instr);

    // fetch_ack during EXEC is ignored
    fetch_ack = 1; instr_in = 32'hDEAD_BEEF;
    @(negedge clk);
    fetch_ack = 0; instr_in = '0;
    chk("ack in EXEC instr", 64'(instr), 64'(w0));
    chk("ack in EXEC instr_valid", 64'(instr_valid), 64'd1);
    chk("ack in EXEC pc", pc, RV);
    $display("ack-in-EXEC: instr=%h", instr);

    // Not-taken BEQ -> 0x1004
    do_exec(mk(1, 0, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0));
    chk("beq nt pc", pc, 64'h1004);
    chk("beq nt taken", 64'(taken), 64'd0);

    // ex_done during FETCH is ignored
    drive_exec(mk(0, 1, 0, 3'b000, 64'h100, 0, 0, 0, 0, 0, 0));
    ex_done = 1;
    repeat (2) @(negedge clk);
    chk("ex_done in FETCH pc", pc, 64'h1004);
    chk("ex_done in FETCH fetch_req", 64'(fetch_req), 64'd1);
    chk("ex_done in FETCH taken", 64'(taken), 64'd0);
    // ack and ex_done together in FETCH: only the ack acts
    fetch_ack = 1; instr_in = 32'h0000_006F;
    @(negedge clk);
    fetch_ack = 0; instr_in = '0;
    clear_exec_inputs();
    chk("ack+ex_done instr_valid", 64'(instr_valid), 64'd1);
    chk("ack+ex_done pc", pc, 64'h1004);
    $display("ex_done-in-FETCH: pc=%h instr_valid=%b", pc, instr_valid);
    do_exec(mk(0, 1, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0));
    chk("jal back pc", pc, RV);
    chk("jal back taken", 64'(taken), 64'd1);

    // Vector table, each row one full fetch+execute from the previous row's pc
    vecs[0]  = mk(0, 1, 0, 3'b000, 64'h10, 0, 0, 0, 0, 64'h1010, 1);                  // JAL
    vecs[1]  = mk(1, 0, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 0, 0, 64'h1008, 1);  // BEQ taken
    vecs[2]  = mk(0, 1, 0, 3'b000, 64'h8, 0, 0, 0, 0, 64'h1010, 1);                   // JAL
    vecs[3]  = mk(1, 0, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, 64'h1014, 0);  // BEQ not
    vecs[4]  = mk(1, 0, 0, 3'b110, 64'h20, 0, 0, 0, 1, 64'h1034, 1);                  // BLTU taken
    vecs[5]  = mk(1, 0, 0, 3'b101, 64'h20, 0, 0, 1, 0, 64'h1038, 0);                  // BGE not
    vecs[6]  = mk(1, 0, 0, 3'b010, 64'h20, 0, 1, 1, 1, 64'h103C, 0);                  // 010 never
    vecs[7]  = mk(1, 0, 0, 3'b001, 64'h40, 0, 0, 0, 0, 64'h107C, 1);                  // BNE taken
    vecs[8]  = mk(1, 0, 0, 3'b100, 64'h40, 0, 0, 0, 0, 64'h1080, 0);                  // BLT not
    vecs[9]  = mk(1, 0, 0, 3'b111, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0, 0, 64'h1000, 1);  // BGEU taken
    vecs[10] = mk(0, 0, 1, 3'b000, 64'h1, 64'h2004, 0, 0, 0, 64'h2004, 1);            // JALR bit0 clear
    vecs[11] = mk(0, 1, 1, 3'b000, 64'h8, 64'h3000, 0, 0, 0, 64'h3008, 1);            // JALR beats JAL
    vecs[12] = mk(0, 0, 1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    vecs[13] = mk(0, 0, 0, 3'b000, 64'h0, 0, 0, 0, 0, 64'h0, 0);                      // wrap to 0
    vecs[14] = mk(0, 1, 0, 3'b000, 64'h1000, 0, 0, 0, 0, 64'h1000, 1);                // JAL home

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      do_fetch(32'h0000_0013 + 32'(i), $sformatf("vec%0d", i));
      do_exec(v);
      chk($sformatf("vec%0d pc", i), pc, v.exp_pc);
      chk($sformatf("vec%0d fetch_addr", i), fetch_addr, v.exp_pc);
      chk($sformatf("vec%0d pc_plus4", i), pc_plus4, v.exp_pc + 64'd4);
      chk($sformatf("vec%0d taken", i), 64'(taken), 64'(v.exp_taken));
      chk($sformatf("vec%0d fetch_req", i), 64'(fetch_req), 64'd1);
      chk($sformatf("vec%0d instr_valid", i), 64'(instr_valid), 64'd0);
      $display("vec %0d: pc=%h taken=%b", i, pc, taken);
    end

    // Reset asserted mid-FETCH
    do_fetch(32'h0000_006F, "pre-reset");
    do_exec(mk(0, 1, 0, 3'b000, 64'h40, 0, 0, 0, 0, 0, 0));
    chk("pre-reset pc", pc, 64'h1040);
    #2 reset = 1;
    #1;
    chk("mid-FETCH reset fetch_req", 64'(fetch_req), 64'd0);
    chk("mid-FETCH reset pc", pc, RV);
    chk("mid-FETCH reset taken", 64'(taken), 64'd0);
    $display("reset mid-FETCH: pc=%h fetch_req=%b", pc, fetch_req);
    @(negedge clk);
    reset = 0;

    // Reset asserted mid-EXEC
    do_fetch(32'h0000_006F, "pre-reset2");
    do_exec(mk(0, 1, 0, 3'b000, 64'h40, 0, 0, 0, 0, 0, 0));
    do_fetch(32'h1234_5678, "exec-reset");
    #2 reset = 1;
    #1;
    chk("mid-EXEC reset instr_valid", 64'(instr_valid), 64'd0);
    chk("mid-EXEC reset instr", 64'(instr), 64'd0);
    chk("mid-EXEC reset pc", pc, RV);
    $display("reset mid-EXEC: pc=%h instr_valid=%b", pc, instr_valid);
    @(negedge clk);
    reset = 0;

    // Misaligned JAL target traps; pc is held and the unit stays parked
    do_fetch(32'h0060_006F, "trap");
    do_exec(mk(0, 1, 0, 3'b000, 64'h6, 0, 0, 0, 0, 0, 0));
    chk("trap misaligned", 64'(misaligned), 64'd1);
    chk("trap pc", pc, RV);
    chk("trap fetch_req", 64'(fetch_req), 64'd0);
    chk("trap instr_valid", 64'(instr_valid), 64'd0);
    fetch_ack = 1; ex_done = 1;
    repeat (3) @(negedge clk);
    fetch_ack = 0; ex_done = 0;
    chk("trap held fetch_req", 64'(fetch_req), 64'd0);
    chk("trap held pc", pc, RV);
    chk("trap held misaligned", 64'(misaligned), 64'd1);
    $display("trap: pc=%h misaligned=%b", pc, misaligned);
    reset = 1;
    #1;
    chk("trap cleared by reset", 64'(misaligned), 64'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
